label_accumulator: RTL and testbench
====================================

// Module: label_accumulator
// PURPOSE
//   Downstream consumer of the sample-memory read-address counter. On start, clears the counter,
//   drives its enable for exactly DEPTH cycles, and captures the returned memory word and label.
//   Accumulates, per label, the sum of sample values and the sample count.
//   Exposes the per-label results through a registered select port for the classifier stage.
// PARAMETERS
//   DEPTH         1024  samples per run (memory depth)
//   LOG_DEPTH     10    address width
//   WIDTH         16    sample width, unsigned
//   DOUBLE_WIDTH  32    accumulator width
//   NUM_LABEL     8     number of labels
//   LOG_NUM_LABEL 3     label width
//   READ_LATENCY  1     cycles from address/enable edge to valid rdata/rlabel; legal range 1..4
// PORTS
//   clk       in   1              rising-edge clock
//   rst       in   1              asynchronous, active-low reset
//   start     in   1              one-cycle run request; ignored while busy
//   addr_clr  out  1              synchronous clear to the address counter (its active-high rst)
//   rd_en     out  1              enable to the address counter; one read per high cycle
//   rdata     in   WIDTH          memory data for the address issued READ_LATENCY cycles earlier
//   rlabel    in   LOG_NUM_LABEL  label paired with rdata
//   busy      out  1              high from start acceptance until done
//   done      out  1              one-cycle pulse when all results are final
//   sel_label in   LOG_NUM_LABEL  result select
//   sum_out   out  DOUBLE_WIDTH   registered sum for sel_label
//   cnt_out   out  LOG_DEPTH+1    registered count for sel_label
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; addr_clr, rd_en, busy, done = 0; all sums, counts, sum_out,
//     cnt_out and the valid pipe = 0.
//   FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
//   - IDLE: start=1 -> CLEAR. Any other input: stay in IDLE.
//   - CLEAR (1 cycle): addr_clr=1. Zero all NUM_LABEL sums and counts. Zero the issue counter.
//   - RUN: rd_en=1 for exactly DEPTH cycles, tracked by a LOG_DEPTH+1-bit issue counter; then DRAIN.
//   - DRAIN: rd_en=0 for READ_LATENCY cycles, so every outstanding read is captured.
//   - DONE (1 cycle): done=1, busy=0; next state IDLE.
//   - busy=1 in CLEAR, RUN and DRAIN only.
//   Timing: start sampled at edge k -> done high in cycle k+DEPTH+2+READ_LATENCY.
//   Valid pipe: rd_en delayed READ_LATENCY cycles gives dvalid.
//     On dvalid: sum[rlabel] += zero-extended rdata; cnt[rlabel] += 1.
//   Widths: max sum = DEPTH*(2^WIDTH-1) < 2^(LOG_DEPTH+WIDTH) <= 2^DOUBLE_WIDTH, so no overflow.
//     Count reaches DEPTH, hence LOG_DEPTH+1 bits.
//   Address wrap: after DEPTH increments the counter returns to 0. This is expected; no extra clear.
//   Result port: sum_out/cnt_out update every cycle from sel_label (1-cycle latency).
//     Values are final from the done cycle and held until the next CLEAR.
//   Simultaneous events: start in DONE or while busy is ignored (no queueing).
//     start in the same cycle that DONE returns to IDLE is honoured only if sampled in IDLE.
//   Reset mid-run: everything aborts to reset values; the next start performs a full clean run.
// STRUCTURE
//   Shared package: DEPTH, LOG_DEPTH, WIDTH, DOUBLE_WIDTH, NUM_LABEL, LOG_NUM_LABEL,
//     FSM state enum (IDLE/CLEAR/RUN/DRAIN/DONE).
//   Sub-module valid_pipe: READ_LATENCY-deep shift register turning rd_en into dvalid,
//     async active-low reset.
//   Accumulator arrays and the result mux stay in this module.
// TESTING
//   1. rdata=1 everywhere, rlabel=addr%8, start once -> each label sum=128, cnt=128;
//      done at k+1027 (READ_LATENCY=1); rd_en high exactly 1024 cycles.
//   2. rdata=16'hFFFF, rlabel=7 everywhere -> sum[7]=67107840, cnt[7]=1024;
//      labels 0..6 read sum=0, cnt=0.
//   3. start pulsed again at RUN cycle 300 -> ignored, single done pulse.
//      Second start after done with rdata=2 -> sums=256, not accumulated onto the prior run.
//   4. rst low for 1 cycle mid-RUN at address 500 -> busy, rd_en, addr_clr, sums = 0 immediately;
//      a fresh start then reproduces test 1 results.
//   5. READ_LATENCY=3 build, test 1 stimulus -> identical sums/counts; done at k+1029;
//      last sample captured.
//   6. Sweep sel_label 0..7 after done -> sum_out/cnt_out match the model, each 1 cycle after select.

Source files
------------

// File: rtl/label_accumulator_pkg.sv
// Shared sizing and FSM encoding for the label accumulator.
package label_accumulator_pkg;
  localparam int DEPTH         = 1024;
  localparam int LOG_DEPTH     = 10;
  localparam int WIDTH         = 16;
  localparam int DOUBLE_WIDTH  = 32;
  localparam int NUM_LABEL     = 8;
  localparam int LOG_NUM_LABEL = 3;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/valid_pipe.sv
// Delays the read enable by the memory read latency so it lines up with rdata.
module valid_pipe #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[STAGES-1];
endmodule

// File: rtl/label_accumulator.sv
// Sweeps the sample memory once per start and accumulates per-label sums and counts.
module label_accumulator
  import label_accumulator_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     addr_clr,
  output logic                     rd_en,
  input  logic [WIDTH-1:0]         rdata,
  input  logic [LOG_NUM_LABEL-1:0] rlabel,
  output logic                     busy,
  output logic                     done,
  input  logic [LOG_NUM_LABEL-1:0] sel_label,
  output logic [DOUBLE_WIDTH-1:0]  sum_out,
  output logic [LOG_DEPTH:0]       cnt_out
);
  state_t                                   state, nxt;
  logic [LOG_DEPTH:0]                       issue_cnt;
  logic [2:0]                               drain_cnt;
  logic                                     dvalid;
  logic [NUM_LABEL-1:0][DOUBLE_WIDTH-1:0]   sums;
  logic [NUM_LABEL-1:0][LOG_DEPTH:0]        cnts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = CLEAR;
      CLEAR: nxt = RUN;
      RUN:   if (issue_cnt == (LOG_DEPTH+1)'(DEPTH-1)) nxt = DRAIN;
      DRAIN: if (drain_cnt == 3'(READ_LATENCY-1)) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_clr = 1'b0;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      CLEAR: begin addr_clr = 1'b1; busy = 1'b1; end
      RUN:   begin rd_en    = 1'b1; busy = 1'b1; end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // issue_cnt counts rd_en cycles; drain_cnt times the tail of in-flight reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        CLEAR: issue_cnt <= '0;
        RUN: begin
          issue_cnt <= issue_cnt + (LOG_DEPTH+1)'(1);
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  valid_pipe #(.STAGES(READ_LATENCY)) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en),
    .dout (dvalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sums <= '0;
      cnts <= '0;
    end else if (state == CLEAR) begin
      sums <= '0;
      cnts <= '0;
    end else if (dvalid) begin
      sums[rlabel] <= sums[rlabel] + DOUBLE_WIDTH'(rdata);
      cnts[rlabel] <= cnts[rlabel] + (LOG_DEPTH+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_out <= '0;
      cnt_out <= '0;
    end else begin
      sum_out <= sums[sel_label];
      cnt_out <= cnts[sel_label];
    end
  end
endmodule

// File: tb/tb_label_accumulator.sv
// Randomized scoreboard bench; runs READ_LATENCY=1 and =3 instances side by side.
module tb_label_accumulator;
  import label_accumulator_pkg::*;

  localparam int NDUT = 2;
  typedef struct { int at; longint s; longint c; } res_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic [LOG_NUM_LABEL-1:0] sel_label = '0;
  logic [NDUT-1:0]          addr_clr, rd_en, busy, done;
  logic [WIDTH-1:0]         rdata   [NDUT];
  logic [LOG_NUM_LABEL-1:0] rlabel  [NDUT];
  logic [DOUBLE_WIDTH-1:0]  sum_out [NDUT];
  logic [LOG_DEPTH:0]       cnt_out [NDUT];

  logic [WIDTH-1:0]         mem_data  [DEPTH];
  logic [LOG_NUM_LABEL-1:0] mem_label [DEPTH];
  longint                   exp_sum [NUM_LABEL];
  longint                   exp_cnt [NUM_LABEL];
  res_t                     res_q[$];
  res_t                     r;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [LOG_DEPTH-1:0] addr;
    logic [LOG_DEPTH-1:0] apipe [LAT];
    int done_q[$];
    int rd_cnt = 0;
    int e;

    label_accumulator #(.READ_LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .addr_clr  (addr_clr[g]),
      .rd_en     (rd_en[g]),
      .rdata     (rdata[g]),
      .rlabel    (rlabel[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .sel_label (sel_label),
      .sum_out   (sum_out[g]),
      .cnt_out   (cnt_out[g])
    );

    // external address counter plus a memory with LAT cycles of read delay
    always @(posedge clk) begin
      if (addr_clr[g])   addr <= '0;
      else if (rd_en[g]) addr <= addr + LOG_DEPTH'(1);
      apipe[0] <= addr;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign rdata[g]  = mem_data[apipe[LAT-1]];
    assign rlabel[g] = mem_label[apipe[LAT-1]];

    always @(negedge clk) if (rst) begin
      if (addr_clr[g]) rd_cnt = 0;
      if (rd_en[g])    rd_cnt++;
      if (done[g]) begin
        if (done_q.size() == 0) chk($sformatf("spurious_done_lat%0d", LAT), 1, 0);
        else begin
          e = done_q.pop_front();
          chk($sformatf("done_cycle_lat%0d", LAT), cyc, e);
          chk($sformatf("rd_en_cycles_lat%0d", LAT), rd_cnt, DEPTH);
        end
      end
    end
  end

  always @(negedge clk) begin
    while (res_q.size() > 0 && res_q[0].at <= cyc) begin
      r = res_q.pop_front();
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("sum_out_dut%0d", i), sum_out[i], r.s);
        chk($sformatf("cnt_out_dut%0d", i), cnt_out[i], r.c);
      end
    end
  end

  task automatic fill(input int mode);
    for (int a = 0; a < DEPTH; a++) begin
      case (mode)
        0: begin mem_data[a] = WIDTH'(1);      mem_label[a] = LOG_NUM_LABEL'(a % 8); end
        1: begin mem_data[a] = 16'hFFFF;       mem_label[a] = LOG_NUM_LABEL'(7); end
        2: begin mem_data[a] = WIDTH'(2);      mem_label[a] = LOG_NUM_LABEL'(a % 8); end
        default: begin
          mem_data[a]  = WIDTH'($urandom);
          mem_label[a] = LOG_NUM_LABEL'($urandom_range(0, 7));
        end
      endcase
    end
  endtask

  // one full pass over memory contents
  task automatic model(input bit zero);
    for (int l = 0; l < NUM_LABEL; l++) begin exp_sum[l] = 0; exp_cnt[l] = 0; end
    if (!zero)
      for (int a = 0; a < DEPTH; a++) begin
        exp_sum[mem_label[a]] += longint'(mem_data[a]);
        exp_cnt[mem_label[a]] += 1;
      end
  endtask

  task automatic do_run(input int mid, input bit late);
    int k;
    int n;
    @(posedge clk); #2 start = 1'b1;
    k = cyc + 1;
    // done fills cycle k+DEPTH+2+LAT, i.e. visible after edge k+DEPTH+1+LAT
    g_dut[0].done_q.push_back(k + DEPTH + 1 + 1);
    g_dut[1].done_q.push_back(k + DEPTH + 1 + 3);
    @(posedge clk); #2 start = 1'b0;
    if (mid > 0) begin
      repeat (mid) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    if (late) begin
      n = 0;
      while (n < 2 * DEPTH) begin
        @(posedge clk); #2;
        n++;
        if (cyc >= k + DEPTH + 2) break;
      end
      start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    n = 0;
    while ((g_dut[0].done_q.size() != 0 || g_dut[1].done_q.size() != 0) && n < DEPTH + 50) begin
      @(posedge clk);
      n++;
    end
    if (g_dut[0].done_q.size() != 0 || g_dut[1].done_q.size() != 0) begin
      chk("done_timeout", 1, 0);
      g_dut[0].done_q.delete();
      g_dut[1].done_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic sweep(input bit rnd);
    int sel;
    for (int l = 0; l < NUM_LABEL; l++) begin
      sel = rnd ? int'($urandom_range(0, 7)) : l;
      @(posedge clk); #2 sel_label = LOG_NUM_LABEL'(sel);
      res_q.push_back('{cyc + 1, exp_sum[sel], exp_cnt[sel]});
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_run();
    int n;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    while (g_dut[0].addr != LOG_DEPTH'(500) && n < 2 * DEPTH) begin
      @(posedge clk); #2;
      n++;
    end
    chk("reach_addr500", g_dut[0].addr, 500);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("midrst_busy%0d", i), busy[i], 0);
      chk($sformatf("midrst_rd_en%0d", i), rd_en[i], 0);
      chk($sformatf("midrst_addr_clr%0d", i), addr_clr[i], 0);
      chk($sformatf("midrst_sum%0d", i), sum_out[i], 0);
      chk($sformatf("midrst_cnt%0d", i), cnt_out[i], 0);
    end
    @(posedge clk); #2 rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_addr_clr%0d", i), addr_clr[i], 0);
      chk($sformatf("rst_rd_en%0d", i), rd_en[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_done%0d", i), done[i], 0);
      chk($sformatf("rst_sum%0d", i), sum_out[i], 0);
      chk($sformatf("rst_cnt%0d", i), cnt_out[i], 0);
    end
    @(posedge clk); #2 rst = 1'b1;

    fill(0); model(0); do_run(0, 0);   sweep(0);
    fill(1); model(0); do_run(0, 0);   sweep(0);
    // stray starts mid-run and in the DONE cycle must not queue a second run
    fill(0); model(0); do_run(300, 1); sweep(0);
    fill(2); model(0); do_run(0, 0);   sweep(0);
    fill(0); reset_mid_run(); model(1); sweep(0);
    fill(0); model(0); do_run(0, 0);   sweep(1);
    fill(3); model(0); do_run(0, 0);   sweep(0);
    sweep(1);

    repeat (3) @(posedge clk);
    if (res_q.size() != 0) chk("res_q_drained", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
